// File: rtl/level_switch_driver_pkg.sv
// Shared types and constants for the level switch driver.
//   - FSM state enum
//   - SW_STATE encodings reported to the slave controller
//   - default counter widths
//   - drive_of(): maps an FSM state to the registered switch drive pattern
package level_switch_pkg;

  localparam int LSD_CNT_W  = 16;
  localparam int LSD_EDGE_W = 16;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_LOW_ON,
    ST_HIGH_ON,
    ST_DEAD
  } lsd_state_e;

  localparam logic [1:0] SW_ST_OFF  = 2'b00;
  localparam logic [1:0] SW_ST_LOW  = 2'b01;
  localparam logic [1:0] SW_ST_HIGH = 2'b10;
  localparam logic [1:0] SW_ST_DEAD = 2'b11;

  typedef struct packed {
    logic       low_en;
    logic       high_en;
    logic [1:0] sw_state;
  } sw_drive_t;

  // Only the ON states may raise an enable, and never both.
  function automatic sw_drive_t drive_of(lsd_state_e s);
    sw_drive_t d;
    d = '0;
    case (s)
      ST_LOW_ON:  begin d.low_en  = 1'b1; d.sw_state = SW_ST_LOW;  end
      ST_HIGH_ON: begin d.high_en = 1'b1; d.sw_state = SW_ST_HIGH; end
      ST_DEAD:    d.sw_state = SW_ST_DEAD;
      default:    d.sw_state = SW_ST_OFF;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/level_switch_driver_if.sv
// Request/report bundle between the slave controller (master side) and the
// level switch driver (slave side).
//   master drives : ENABLE, LEVEL_SEL, DEAD_TIME, MIN_HOLD
//   slave drives  : SW_LOW_EN, SW_HIGH_EN, SW_STATE, EDGE_COUNT,
//                   EDGE_COUNT_VALID, HOLD_DROP
interface level_switch_driver_if
  import level_switch_pkg::*;
#(
  parameter int CNT_W  = LSD_CNT_W,
  parameter int EDGE_W = LSD_EDGE_W
);

  logic              ENABLE;
  logic              LEVEL_SEL;
  logic [CNT_W-1:0]  DEAD_TIME;
  logic [CNT_W-1:0]  MIN_HOLD;
  logic              SW_LOW_EN;
  logic              SW_HIGH_EN;
  logic [1:0]        SW_STATE;
  logic [EDGE_W-1:0] EDGE_COUNT;
  logic              EDGE_COUNT_VALID;
  logic              HOLD_DROP;

  modport master (
    output ENABLE, LEVEL_SEL, DEAD_TIME, MIN_HOLD,
    input  SW_LOW_EN, SW_HIGH_EN, SW_STATE, EDGE_COUNT, EDGE_COUNT_VALID, HOLD_DROP
  );

  modport slave (
    input  ENABLE, LEVEL_SEL, DEAD_TIME, MIN_HOLD,
    output SW_LOW_EN, SW_HIGH_EN, SW_STATE, EDGE_COUNT, EDGE_COUNT_VALID, HOLD_DROP
  );

endinterface

// File: rtl/level_switch_driver_vsync_rise_sync.sv
// Brings the asynchronous frame sync into the REF_CLK domain and flags its
// rising edge.
//   REF_CLK : clock
//   nRESET  : async active-low reset, all flops cleared
//   vsync   : asynchronous frame sync
//   vs_rise : one-cycle pulse after a synchronised rising edge
module vsync_rise_sync (
  input  logic REF_CLK,
  input  logic nRESET,
  input  logic vsync,
  output logic vs_rise
);

  logic sync_q1;
  logic sync_q2;
  logic sync_prev;

  always_ff @(posedge REF_CLK or negedge nRESET) begin
    if (!nRESET) begin
      sync_q1   <= 1'b0;
      sync_q2   <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_q1   <= vsync;
      sync_q2   <= sync_q1;
      sync_prev <= sync_q2;
    end
  end

  assign vs_rise = sync_q2 & ~sync_prev;

endmodule

// File: rtl/level_switch_driver.sv
// Level switch driver: turns the LEVEL_SEL request into two mutually
// exclusive analog-switch enables with break-before-make dead time and a
// minimum on-hold, and reports per-frame polarity-change counts.
//   REF_CLK : clock, all logic on posedge
//   nRESET  : async active-low reset; drops both enables immediately
//   VSYNC   : asynchronous frame sync (rising edge used)
//   bus     : slave side of level_switch_driver_if (requests in, status out)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// OFF      | both enables off, waiting for ENABLE
// LOW_ON   | low-level switch on, hold counter running
// HIGH_ON  | high-level switch on, hold counter running
// DEAD     | both enables off for D cycles before the next ON state
module level_switch_driver
  import level_switch_pkg::*;
#(
  parameter int CNT_W  = LSD_CNT_W,
  parameter int EDGE_W = LSD_EDGE_W
) (
  input  logic REF_CLK,
  input  logic nRESET,
  input  logic VSYNC,
  level_switch_driver_if.slave bus
);

  logic              vs_rise;
  logic [CNT_W-1:0]  dead_act;
  logic [CNT_W-1:0]  hold_act;
  logic [CNT_W-1:0]  dead_cnt;
  logic [CNT_W-1:0]  hold_cnt;
  logic [CNT_W-1:0]  dead_eff;
  lsd_state_e        state;
  sw_drive_t         drive;
  logic              pending;
  logic              hold_drop;
  logic              last_valid;
  logic              last_lvl;
  logic [EDGE_W-1:0] run_cnt;
  logic [EDGE_W-1:0] edge_count;
  logic              edge_valid;

  logic       cur_lvl;
  logic       lvl_differs;
  logic       hold_met;
  logic       on_entry;
  logic       edge_evt;
  lsd_state_e on_target;

  vsync_rise_sync u_vsync (
    .REF_CLK (REF_CLK),
    .nRESET  (nRESET),
    .vsync   (VSYNC),
    .vs_rise (vs_rise)
  );

  // A programmed dead time of 0 still yields one break cycle.
  assign dead_eff    = (dead_act == '0) ? CNT_W'(1) : dead_act;
  assign cur_lvl     = (state == ST_HIGH_ON);
  assign lvl_differs = (bus.LEVEL_SEL != cur_lvl);
  assign hold_met    = (hold_cnt >= hold_act);
  assign on_target   = bus.LEVEL_SEL ? ST_HIGH_ON : ST_LOW_ON;
  // The ON level is the LEVEL_SEL seen on the final dead cycle, so a
  // request that reverts during DEAD lands back on the old level.
  assign on_entry    = bus.ENABLE && (state == ST_DEAD) && (dead_cnt == CNT_W'(1));
  assign edge_evt    = on_entry && last_valid && (last_lvl != bus.LEVEL_SEL);

  always_ff @(posedge REF_CLK or negedge nRESET) begin
    if (!nRESET) begin
      state     <= ST_OFF;
      drive     <= '0;
      dead_cnt  <= '0;
      hold_cnt  <= '0;
      pending   <= 1'b0;
      hold_drop <= 1'b0;
    end else begin
      hold_drop <= 1'b0;
      if (!bus.ENABLE) begin
        state   <= ST_OFF;
        drive   <= drive_of(ST_OFF);
        pending <= 1'b0;
      end else begin
        case (state)
          ST_OFF: begin
            state    <= ST_DEAD;
            drive    <= drive_of(ST_DEAD);
            dead_cnt <= dead_eff;
          end
          ST_LOW_ON, ST_HIGH_ON: begin
            if (lvl_differs && hold_met) begin
              state    <= ST_DEAD;
              drive    <= drive_of(ST_DEAD);
              dead_cnt <= dead_eff;
              pending  <= 1'b0;
            end else begin
              if (hold_cnt != '1) hold_cnt <= hold_cnt + CNT_W'(1);
              if (lvl_differs) begin
                pending <= 1'b1;
              end else if (pending) begin
                // Withdrawn while still blocked by the hold: report it.
                pending   <= 1'b0;
                hold_drop <= ~hold_met;
              end
            end
          end
          ST_DEAD: begin
            if (dead_cnt == CNT_W'(1)) begin
              state    <= on_target;
              drive    <= drive_of(on_target);
              hold_cnt <= CNT_W'(1);
            end else begin
              dead_cnt <= dead_cnt - CNT_W'(1);
            end
          end
          default: begin
            state <= ST_OFF;
            drive <= drive_of(ST_OFF);
          end
        endcase
      end
    end
  end

  // Frame bookkeeping: shadow config, last ON level, edge counters.
  always_ff @(posedge REF_CLK or negedge nRESET) begin
    if (!nRESET) begin
      dead_act   <= '0;
      hold_act   <= '0;
      last_valid <= 1'b0;
      last_lvl   <= 1'b0;
      run_cnt    <= '0;
      edge_count <= '0;
      edge_valid <= 1'b0;
    end else begin
      if (!bus.ENABLE) begin
        last_valid <= 1'b0;
      end else if (on_entry) begin
        last_valid <= 1'b1;
        last_lvl   <= bus.LEVEL_SEL;
      end

      edge_valid <= vs_rise;
      if (vs_rise) begin
        edge_count <= run_cnt;
        run_cnt    <= edge_evt ? EDGE_W'(1) : '0;
        dead_act   <= bus.DEAD_TIME;
        hold_act   <= bus.MIN_HOLD;
      end else if (edge_evt && (run_cnt != '1)) begin
        run_cnt <= run_cnt + EDGE_W'(1);
      end
    end
  end

  assign bus.SW_LOW_EN        = drive.low_en;
  assign bus.SW_HIGH_EN       = drive.high_en;
  assign bus.SW_STATE         = drive.sw_state;
  assign bus.EDGE_COUNT       = edge_count;
  assign bus.EDGE_COUNT_VALID = edge_valid;
  assign bus.HOLD_DROP        = hold_drop;

endmodule

// File: tb/tb_level_switch_driver.sv
module tb_level_switch_driver;
  import level_switch_pkg::*;

  logic REF_CLK = 1'b0;
  logic nRESET  = 1'b0;
  logic VSYNC   = 1'b0;

  level_switch_driver_if bus ();

  level_switch_driver dut (
    .REF_CLK (REF_CLK),
    .nRESET  (nRESET),
    .VSYNC   (VSYNC),
    .bus     (bus)
  );

  always #5 REF_CLK = ~REF_CLK;

  int total = 0;
  int bad   = 0;

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int P_OFF  = 0;
  localparam int P_ON   = 1;
  localparam int P_DEAD = 2;
  localparam int SAT    = 65535;

  int m_phase = P_OFF;
  int m_lvl   = 0;      // level while ON
  int m_age   = 0;      // cycles spent ON, saturating
  int m_left  = 0;      // dead cycles remaining
  int m_pend  = 0;
  int m_last  = -1;     // last ON level, -1 = none since OFF
  int m_run   = 0;
  int m_ec    = 0;
  int m_ecv   = 0;
  int m_hd    = 0;
  int m_dt    = 0;
  int m_mh    = 0;
  bit h1 = 0, h2 = 0, h3 = 0;   // VSYNC as sampled on the last three edges

  task automatic m_reset();
    m_phase = P_OFF; m_lvl = 0; m_age = 0; m_left = 0; m_pend = 0;
    m_last = -1; m_run = 0; m_ec = 0; m_ecv = 0; m_hd = 0;
    m_dt = 0; m_mh = 0; h1 = 0; h2 = 0; h3 = 0;
  endtask

  task automatic m_step();
    bit vr;
    int edge_now;
    int sel;
    bit met;
    vr = h2 && !h3;
    edge_now = 0;
    sel = int'(bus.LEVEL_SEL);
    m_hd = 0;
    if (!bus.ENABLE) begin
      m_phase = P_OFF; m_pend = 0; m_last = -1;
    end else if (m_phase == P_OFF) begin
      m_phase = P_DEAD;
      m_left = (m_dt == 0) ? 1 : m_dt;
    end else if (m_phase == P_ON) begin
      met = (m_age >= m_mh);
      if (sel != m_lvl) begin
        if (met) begin
          m_phase = P_DEAD;
          m_left = (m_dt == 0) ? 1 : m_dt;
          m_pend = 0;
        end else m_pend = 1;
      end else if (m_pend != 0) begin
        m_hd = met ? 0 : 1;
        m_pend = 0;
      end
      if (m_phase == P_ON && m_age < SAT) m_age++;
    end else begin
      if (m_left == 1) begin
        m_phase = P_ON;
        m_lvl = sel;
        m_age = 1;
        edge_now = (m_last >= 0 && m_last != sel) ? 1 : 0;
        m_last = sel;
      end else m_left--;
    end
    if (vr) begin
      m_ec = m_run; m_ecv = 1; m_run = edge_now;
      m_dt = int'(bus.DEAD_TIME); m_mh = int'(bus.MIN_HOLD);
    end else begin
      m_ecv = 0;
      if (edge_now != 0 && m_run < SAT) m_run++;
    end
    h3 = h2; h2 = h1; h1 = VSYNC;
  endtask

  initial begin
    forever begin
      @(posedge REF_CLK or negedge nRESET);
      if (!nRESET) m_reset();
      else m_step();
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge REF_CLK);
      cmp("sw_low_en",  int'(bus.SW_LOW_EN),  (m_phase == P_ON && m_lvl == 0) ? 1 : 0);
      cmp("sw_high_en", int'(bus.SW_HIGH_EN), (m_phase == P_ON && m_lvl == 1) ? 1 : 0);
      cmp("sw_state",   int'(bus.SW_STATE),
          (m_phase == P_OFF) ? 0 : (m_phase == P_DEAD) ? 3 : (m_lvl == 1 ? 2 : 1));
      cmp("edge_count", int'(bus.EDGE_COUNT), m_ec);
      cmp("edge_valid", int'(bus.EDGE_COUNT_VALID), m_ecv);
      cmp("hold_drop",  int'(bus.HOLD_DROP), m_hd);
      cmp("no_overlap", int'(bus.SW_LOW_EN & bus.SW_HIGH_EN), 0);
      assert (!(bus.SW_LOW_EN && bus.SW_HIGH_EN)) else $error("both switch enables high");
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge REF_CLK);
  endtask

  // VSYNC pulse loading new config; returns reported count and pulse count.
  task automatic vs_frame(input int dt, input int mh, output int ec, output int np);
    ec = -1;
    np = 0;
    bus.DEAD_TIME = 16'(dt);
    bus.MIN_HOLD  = 16'(mh);
    VSYNC = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (bus.EDGE_COUNT_VALID) begin
        if (np == 0) ec = int'(bus.EDGE_COUNT);
        np++;
      end
      if (i == 2) VSYNC = 1'b0;
    end
    cmp("vsync_report_seen", (np > 0) ? 1 : 0, 1);
  endtask

  int ec, np, drops, all_high;

  initial begin
    bus.ENABLE = 1'b0; bus.LEVEL_SEL = 1'b0;
    bus.DEAD_TIME = '0; bus.MIN_HOLD = '0;
    step(3);
    cmp("rst_state", int'(bus.SW_STATE), 0);
    cmp("rst_low",   int'(bus.SW_LOW_EN), 0);
    cmp("rst_ec",    int'(bus.EDGE_COUNT), 0);
    nRESET = 1'b1;
    step(2);

    // Enable with dead time 0 -> one dead cycle, then LOW.
    bus.ENABLE = 1'b1; bus.LEVEL_SEL = 1'b0;
    step(1);
    cmp("t1_dead_state", int'(bus.SW_STATE), 3);
    cmp("t1_low_off",    int'(bus.SW_LOW_EN), 0);
    step(1);
    cmp("t1_low_state",  int'(bus.SW_STATE), 1);
    cmp("t1_low_on",     int'(bus.SW_LOW_EN), 1);

    // Dead 4 / hold 3, LOW -> HIGH.
    vs_frame(4, 3, ec, np);
    cmp("t2_ec", ec, 0);
    cmp("t2_valid_width", np, 1);
    step(2);
    bus.LEVEL_SEL = 1'b1;
    step(1);
    cmp("t2_low_dropped", int'(bus.SW_LOW_EN), 0);
    cmp("t2_dead",        int'(bus.SW_STATE), 3);
    step(3);
    cmp("t2_high_waits",  int'(bus.SW_HIGH_EN), 0);
    step(1);
    cmp("t2_high_on",     int'(bus.SW_HIGH_EN), 1);
    cmp("t2_high_state",  int'(bus.SW_STATE), 2);

    // Back to LOW while loading hold 8; then withdrawn request in HIGH.
    step(3);
    bus.LEVEL_SEL = 1'b0;
    vs_frame(4, 8, ec, np);
    cmp("t3_ec", ec, 1);
    step(10);
    bus.LEVEL_SEL = 1'b1;
    step(5);
    cmp("t3_high", int'(bus.SW_HIGH_EN), 1);
    step(1);
    bus.LEVEL_SEL = 1'b0;
    drops = 0; all_high = 1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (bus.HOLD_DROP) drops++;
      if (!bus.SW_HIGH_EN) all_high = 0;
      if (i == 1) bus.LEVEL_SEL = 1'b1;
    end
    cmp("t3_drops", drops, 1);
    cmp("t3_high_kept", all_high, 1);

    // Dead 5, request reverts during DEAD.
    vs_frame(5, 3, ec, np);
    cmp("t4_prev_ec", ec, 2);
    bus.LEVEL_SEL = 1'b0;
    step(1);
    cmp("t4_dead", int'(bus.SW_STATE), 3);
    bus.LEVEL_SEL = 1'b1;
    step(4);
    cmp("t4_still_dead", int'(bus.SW_STATE), 3);
    step(1);
    cmp("t4_back_high", int'(bus.SW_STATE), 2);
    step(5);

    // Three polarity changes in one frame.
    bus.LEVEL_SEL = 1'b0; step(12);
    bus.LEVEL_SEL = 1'b1; step(12);
    bus.LEVEL_SEL = 1'b0; step(12);
    vs_frame(5, 3, ec, np);
    cmp("t5_ec", ec, 3);
    cmp("t5_valid_width", np, 1);
    step(5);

    // ON entry lands on the same edge as vs_rise.
    bus.LEVEL_SEL = 1'b1;
    step(3);
    VSYNC = 1'b1;
    step(4);
    VSYNC = 1'b0;
    step(10);
    vs_frame(5, 3, ec, np);
    cmp("t5_coincide_ge1", (ec >= 1) ? 1 : 0, 1);
    cmp("t5_coincide_ec", ec, 1);

    // Async reset while HIGH.
    step(3);
    cmp("t6_pre_high", int'(bus.SW_HIGH_EN), 1);
    #2 nRESET = 1'b0;
    #1;
    cmp("t6_rst_high", int'(bus.SW_HIGH_EN), 0);
    cmp("t6_rst_low",  int'(bus.SW_LOW_EN), 0);
    cmp("t6_rst_state", int'(bus.SW_STATE), 0);
    step(2);
    nRESET = 1'b1;
    step(4);
    vs_frame(5, 2, ec, np);
    step(5);

    // ENABLE drop in the middle of DEAD.
    bus.LEVEL_SEL = 1'b0;
    step(2);
    cmp("t6_dead", int'(bus.SW_STATE), 3);
    bus.ENABLE = 1'b0;
    step(1);
    cmp("t6_off_state", int'(bus.SW_STATE), 0);
    cmp("t6_off_low",   int'(bus.SW_LOW_EN), 0);
    cmp("t6_off_high",  int'(bus.SW_HIGH_EN), 0);
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/level_switch_driver.md
Name: level_switch_driver

Overview:
- Downstream consumer of the timing generator's LEVEL_SEL output.
- Converts the LEVEL_SEL request into two mutually exclusive analog-switch enables, SW_LOW_EN and SW_HIGH_EN.
- Enforces programmable break-before-make dead time and a minimum on-hold time, so glitches never short the two supply levels.
- Reports per-frame switch-edge counts and dropped-request pulses to the slave controller.

Parameters:
- CNT_W, 16, width of the DEAD_TIME, MIN_HOLD and hold/dead counters.
- EDGE_W, 16, width of the edge counters (saturating).

Ports:
- REF_CLK  in  1  clock, all logic on posedge.
- nRESET  in  1  reset, asynchronous, active-low.
- ENABLE  in  1  1 = drive switches; 0 = both enables off.
- LEVEL_SEL  in  1  requested level (1 = HIGH, 0 = LOW); already REF_CLK-synchronous.
- VSYNC  in  1  asynchronous frame sync; the rising edge is used.
- DEAD_TIME  in  CNT_W  break-before-make cycles; shadowed.
- MIN_HOLD  in  CNT_W  minimum cycles an enable stays on; shadowed.
- SW_LOW_EN  out  1  low-level switch enable.
- SW_HIGH_EN  out  1  high-level switch enable.
- SW_STATE  out  2  00 = OFF, 01 = LOW, 10 = HIGH, 11 = DEAD.
- EDGE_COUNT  out  EDGE_W  number of completed polarity changes in the last frame.
- EDGE_COUNT_VALID  out  1  one-cycle pulse when EDGE_COUNT updates.
- HOLD_DROP  out  1  one-cycle pulse when a request was withdrawn before MIN_HOLD allowed it.

Behaviour:
- Reset (async): SW_LOW_EN = 0, SW_HIGH_EN = 0, SW_STATE = 00, EDGE_COUNT = 0, EDGE_COUNT_VALID = 0, HOLD_DROP = 0, all counters 0, active config = 0, FSM = OFF.
- Reset asserted mid-operation: both enables drop immediately with no dead-time sequencing.
- VSYNC path:
  - 2-flop synchroniser, then rising-edge detect giving a one-cycle vs_rise.
  - On vs_rise, DEAD_TIME and MIN_HOLD are copied into the active registers.
  - The dead counter is loaded only on DEAD entry, so a new value affects the next dead interval only.
  - The hold compare uses the active MIN_HOLD live.
- Effective dead time D = max(active DEAD_TIME, 1), so break-before-make is always at least 1 cycle.
- FSM states: OFF, LOW_ON, HIGH_ON, DEAD. Target level is captured on DEAD entry. Enables are registered outputs decoded from the next state.
  - OFF: if ENABLE = 1, go to DEAD with D loaded.
  - LOW_ON / HIGH_ON: hold_cnt starts at 1 on entry and saturates at all-ones.
    - If LEVEL_SEL differs from the current level and hold_cnt >= active MIN_HOLD, go to DEAD.
    - If LEVEL_SEL differs but the hold is unmet, the request is pending.
    - If LEVEL_SEL returns to the current level while a request is pending and the hold is still unmet, pulse HOLD_DROP for 1 cycle and clear the pending request.
  - DEAD: both enables 0; dead_cnt counts down from D. When dead_cnt reaches 1, go to the ON state matching the LEVEL_SEL sampled that cycle, not the captured target.
- ENABLE = 0 in any state: next cycle both enables 0 and FSM = OFF; pending request cleared.
- Timing: LEVEL_SEL sampled at cycle t with hold met → old enable low at t+1, new enable high at t+1+D.
- SW_LOW_EN & SW_HIGH_EN is never 1; this is an assertion in the bench.
- Edge counting: run_cnt increments, saturating at 2^EDGE_W - 1, on entering an ON state whose level differs from the last ON level. The last ON level is cleared on OFF, so the first ON after OFF is not counted.
- On vs_rise: EDGE_COUNT <= run_cnt, EDGE_COUNT_VALID = 1 for 1 cycle, run_cnt <= 0. If an edge coincides with vs_rise, run_cnt <= 1.

Decomposition:
- Package level_switch_pkg holds:
  - the FSM state enum;
  - the SW_STATE encodings (OFF = 2'b00, LOW = 2'b01, HIGH = 2'b10, DEAD = 2'b11);
  - the default CNT_W and EDGE_W.
- One sub-module, vsync_rise_sync: 2-flop synchroniser plus rising-edge detect producing vs_rise, reset to 0.

Test Plan:
- Reset release, ENABLE = 1, LEVEL_SEL = 0, DEAD_TIME = 0 → SW_LOW_EN rises 2 cycles after ENABLE is sampled (DEAD uses D = 1); SW_STATE sequence 11 then 01.
- vs_rise loads DEAD_TIME = 4, MIN_HOLD = 3; LEVEL_SEL 0→1 after 10 cycles LOW → SW_LOW_EN low at t+1, SW_HIGH_EN high at t+5; enables never both 1.
- MIN_HOLD = 8; LEVEL_SEL toggles 1 cycle after entering HIGH_ON and returns 2 cycles later → no switch, HOLD_DROP pulses exactly once, SW_HIGH_EN stays 1.
- LEVEL_SEL reverts during DEAD (DEAD_TIME = 5) → ON state matches LEVEL_SEL at dead end; run_cnt not incremented.
- Frame with 3 LOW/HIGH changes, then VSYNC rise → EDGE_COUNT = 3 with a 1-cycle EDGE_COUNT_VALID; edge coinciding with vs_rise → next frame reports ≥ 1.
- nRESET asserted mid-HIGH_ON and ENABLE = 0 mid-DEAD → both enables 0 immediately (reset) or next cycle (ENABLE); SW_STATE = 00.
